ps2_poly_voice: RTL

- Polyphonic successor to the single-scan-code note decoder.
- Drains PS/2 scan codes from the `ps2_keyboard` receiver via its `ready`/`nextdata_n` handshake and decodes make/break sequences (F0, E0 prefixes).
- Keeps a table of NUM_VOICES held notes and outputs per-voice phase increments plus a mixed average increment for the audio DDS (48 kHz sample rate, 16-bit phase).
- Sits between `ps2_keyboard` and the sine generator; the display logic reads the voice table.

---
 rtl/ps2_poly_voice.sv | 136 +++++++++++++
 1 files changed

// File: rtl/ps2_poly_voice.sv
// ps2_poly_voice: drains PS/2 scan codes, keeps a polyphonic note table and mixes phase increments.
// Optional macro OCTAVE_SHIFT_EN: '=' / '-' keys shift the octave of newly loaded voices (-2..+2).
module ps2_poly_voice #(
    parameter int NUM_VOICES = 3,
    parameter int STEAL_EN   = 0,
    parameter int FREQ_W     = 16
) (
    input  logic                         clk,
    input  logic                         clrn,
    input  logic                         ready,
    input  logic [7:0]                   data,
    output logic                         nextdata_n,
    output logic [NUM_VOICES-1:0]        voice_valid,
    output logic [8*NUM_VOICES-1:0]      voice_code,
    output logic [FREQ_W*NUM_VOICES-1:0] voice_freq,
    output logic [FREQ_W-1:0]            freq,
    output logic [3:0]                   active_cnt,
    output logic [7:0]                   last_code,
    output logic                         drop
);
    typedef enum logic [1:0] {IDLE, POP, GAP} state_t;
    state_t state, state_d;
    logic pop, prefix, mk, bk, hit, full, load;
    logic [7:0] byte_r;
    logic ext, brk;
    logic [2:0] ptr, free_idx, load_idx;
    logic [7:0] code_r [NUM_VOICES];
    logic [FREQ_W-1:0] inc_r [NUM_VOICES];
    logic [FREQ_W-1:0] base, inc;
    logic [NUM_VOICES-1:0] match;
    logic [FREQ_W+2:0] sum;
    logic [3:0] cnt;

    function automatic logic [FREQ_W-1:0] base_inc(input logic [7:0] c);
        case (c)
            8'h1C:   return FREQ_W'(714);
            8'h1B:   return FREQ_W'(802);
            8'h23:   return FREQ_W'(900);
            8'h2B:   return FREQ_W'(954);
            8'h34:   return FREQ_W'(1070);
            8'h33:   return FREQ_W'(1201);
            8'h3B:   return FREQ_W'(1349);
            8'h42:   return FREQ_W'(1429);
            default: return '0;
        endcase
    endfunction

    always_ff @(posedge clk or negedge clrn)
        if (!clrn) state <= IDLE;
        else state <= state_d;

    always_comb begin
        pop = state == IDLE && ready;
        state_d = state == IDLE ? (ready ? POP : IDLE) : state == POP ? GAP : IDLE;
    end

    always_comb begin
        base = base_inc(byte_r);
        prefix = byte_r == 8'hE0 || byte_r == 8'hF0;
        mk = state == POP && !prefix && !ext && !brk;
        bk = state == POP && !prefix && !ext && brk;
        free_idx = '0;
        sum = '0;
        cnt = '0;
        match = '0;
        // descending scan leaves the lowest free index in free_idx
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            match[i] = voice_valid[i] && code_r[i] == byte_r;
            free_idx = voice_valid[i] ? free_idx : 3'(i);
            sum = sum + (voice_valid[i] ? {3'b0, inc_r[i]} : '0);
            cnt = cnt + {3'b0, voice_valid[i]};
        end
        full = &voice_valid;
        hit = |match;
        load = mk && base != '0 && !hit && (!full || STEAL_EN != 0);
        load_idx = full ? ptr : free_idx;
    end

`ifdef OCTAVE_SHIFT_EN
    logic [2:0] oct;
    assign inc = (base << (oct[2] ? 2'd0 : oct[1:0])) >> (oct[2] ? 2'(3'd0 - oct) : 2'd0);

    always_ff @(posedge clk or negedge clrn)
        if (!clrn) oct <= '0;
        else if (mk && byte_r == 8'h55 && oct != 3'd2) oct <= oct + 3'd1;
        else if (mk && byte_r == 8'h4E && oct != 3'b110) oct <= oct - 3'd1;
`else
    assign inc = base;
`endif

    always_ff @(posedge clk or negedge clrn)
        if (!clrn) begin
            nextdata_n <= 1'b1;
            byte_r <= '0;
            ext <= 1'b0;
            brk <= 1'b0;
            ptr <= '0;
            voice_valid <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                code_r[i] <= '0;
                inc_r[i] <= '0;
            end
            freq <= '0;
            active_cnt <= '0;
            last_code <= '0;
            drop <= 1'b0;
        end else begin
            nextdata_n <= !pop;
            drop <= mk && base != '0 && !hit && full && STEAL_EN == 0;
            active_cnt <= cnt;
            freq <= cnt == 4'd0 ? '0 : FREQ_W'(sum / {{(FREQ_W-1){1'b0}}, cnt});
            if (pop) byte_r <= data;
            if (state == POP) begin
                ext <= byte_r == 8'hE0 || (byte_r == 8'hF0 && ext);
                brk <= byte_r == 8'hF0 || (byte_r == 8'hE0 && brk);
            end
            if (load) last_code <= byte_r;
            if (load && full) ptr <= ptr == 3'(NUM_VOICES - 1) ? 3'd0 : ptr + 3'd1;
            for (int i = 0; i < NUM_VOICES; i++)
                if (bk && match[i]) begin
                    voice_valid[i] <= 1'b0;
                    code_r[i] <= '0;
                    inc_r[i] <= '0;
                end else if (load && load_idx == 3'(i)) begin
                    voice_valid[i] <= 1'b1;
                    code_r[i] <= byte_r;
                    inc_r[i] <= inc;
                end
        end

    always_comb
        for (int i = 0; i < NUM_VOICES; i++) begin
            voice_code[8*i +: 8] = code_r[i];
            voice_freq[FREQ_W*i +: FREQ_W] = inc_r[i];
        end
endmodule
